// File: rtl/ifu_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Used by fetch_fifo and inst_fetch_unit.
package ifu_pkg;

  localparam int IFU_XLEN = 64;
  localparam logic [IFU_XLEN-1:0] IFU_RESET_PC = '0;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic {
    S_FETCH,
    S_FLUSH
  } state_e;

  typedef struct packed {
    logic [IFU_XLEN-1:0] pc;
    logic [31:0]         inst;
  } entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} entries.
// Clear wins over push/pop in the same cycle.
module fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  entry_t        data_i,
  input  logic          pop_i,
  input  logic          clear_i,
  output entry_t        head_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: PC, credit-limited in-order imem requests, instruction buffer.
// Optional IFU_MISALIGN_CHECK_EN adds a sticky if_fetch_fault output.
module inst_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              XLEN       = IFU_XLEN,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = IFU_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_inst,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic            if_fetch_fault
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(FIFO_DEPTH);

  state_e          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] resp_pc_q;
  logic [CW-1:0]   out_q;
  logic [CW-1:0]   out_left;
  logic [CW-1:0]   fifo_cnt;
  logic            fifo_empty;
  logic            fault;
  logic            credit_ok;
  logic            req_fire;
  logic            resp_ok;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redir_tgt;
  entry_t          push_e;
  entry_t          head;

  // Credit uses the registered count: a pop frees a slot next cycle.
  assign credit_ok = ({1'b0, out_q} + {1'b0, fifo_cnt}) < DEPTH_W;

  assign imem_req_valid = !rst && !fault && (state_q == S_FETCH)
                          && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign resp_ok  = imem_resp_valid && (out_q != '0);
  assign out_left = out_q - CW'(resp_ok);
  assign push     = resp_ok && (state_q == S_FETCH) && !redirect_valid;
  assign pop      = if_valid && if_ready && !redirect_valid;
  assign push_e   = '{pc: resp_pc_q, inst: imem_resp_data};

  assign redir_tgt = {redirect_pc[XLEN-1:2], 2'b00};

`ifdef IFU_MISALIGN_CHECK_EN
  logic fault_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
      fault_q <= 1'b1;
    end
  end

  assign fault          = fault_q;
  assign if_fetch_fault = fault_q;
`else
  logic unused_lsb;

  assign unused_lsb = ^redirect_pc[1:0];
  assign fault      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
    end else begin
      out_q <= out_left + CW'(req_fire);
      if (redirect_valid) begin
        pc_q      <= redir_tgt;
        resp_pc_q <= redir_tgt;
        state_q   <= (out_left == '0) ? S_FETCH : S_FLUSH;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + XLEN'(4);
        end
        if (push) begin
          resp_pc_q <= resp_pc_q + XLEN'(4);
        end
        if ((state_q == S_FLUSH) && (out_left == '0)) begin
          state_q <= S_FETCH;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_e),
    .pop_i   (pop),
    .clear_i (redirect_valid),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign if_valid    = !fifo_empty && !fault;
  assign if_inst     = if_valid ? head.inst : '0;
  assign if_pc       = if_valid ? head.pc : '0;
  assign if_pc_plus4 = if_valid ? head.pc + XLEN'(4) : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: vector table, corner sequences, scoreboard.
// Memory model answers in order with a per-address word and set latency.
module tb_inst_fetch_unit;
  import ifu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic [63:0] if_pc_plus4;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        if_fetch_fault;
`endif

  inst_fetch_unit #(
    .XLEN       (64),
    .FIFO_DEPTH (2),
    .RESET_PC   (64'h0)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .if_valid        (if_valid),
    .if_ready        (if_ready),
    .if_inst         (if_inst),
    .if_pc           (if_pc),
    .if_pc_plus4     (if_pc_plus4)
`ifdef IFU_MISALIGN_CHECK_EN
    ,
    .if_fetch_fault  (if_fetch_fault)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
  } exp_t;

  typedef struct {
    bit          redir;
    logic [63:0] rpc;
    bit          rdy;
    bit          e_rv;
    logic [63:0] e_addr;
    bit          e_iv;
    logic [63:0] e_pc;
  } vec_t;

  pend_t       pend[$];
  exp_t        exp_q[$];
  vec_t        tbl[12];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;
  bit          lat_rand = 0;
  bit          rdy_rand = 0;
  int          nfire = 0;
  int          npop = 0;
  int          base;
  logic [63:0] exp_pc = 64'h0;

  function automatic logic [31:0] word(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cyc %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void chk1(string nm, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, want %b (cyc %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic vec_t mk(bit r, logic [63:0] rp, bit rd, bit erv,
                              logic [63:0] ea, bit eiv, logic [63:0] ep);
    vec_t v;
    v.redir  = r;
    v.rpc    = rp;
    v.rdy    = rd;
    v.e_rv   = erv;
    v.e_addr = ea;
    v.e_iv   = eiv;
    v.e_pc   = ep;
    return v;
  endfunction

  // Drive memory for this cycle, settle, then account fires/pops.
  task automatic cycle_begin();
    exp_t e;
    imem_req_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    #1;
    if (imem_req_valid && imem_req_ready) begin
      int due;
      chk("req_addr", imem_req_addr, exp_pc);
      if (lat_rand) lat = $urandom_range(1, 3);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: imem_req_addr, due: due});
      exp_q.push_back('{pc: exp_pc, inst: word(exp_pc)});
      exp_pc += 64'd4;
      nfire++;
    end
    if (if_valid && if_ready && !redirect_valid) begin
      npop++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc 0x%0h, want no instruction", if_pc);
      end else begin
        e = exp_q.pop_front();
        chk("if_pc", if_pc, e.pc);
        chk("if_inst", 64'(if_inst), 64'(e.inst));
        chk("if_pc_plus4", if_pc_plus4, e.pc + 64'd4);
      end
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_pc = {redirect_pc[63:2], 2'b00};
    end
  endtask

  task automatic cycle_end();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      cycle_begin();
      cycle_end();
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    if_ready        = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    @(posedge clk);
    #1;
    cyc++;
    pend.delete();
    exp_q.delete();
    exp_pc = 64'h0;
    rst    = 1'b0;
  endtask

  task automatic wait_first_pc(string nm, logic [63:0] pc);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      cycle_begin();
      if (if_valid) begin
        chk(nm, if_pc, pc);
        chk({nm, "_plus4"}, if_pc_plus4, pc + 64'd4);
        got = 1'b1;
      end
      cycle_end();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no if_valid within 20 cycles, want pc 0x%0h", nm, pc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    if_ready        = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_inst", 64'(if_inst), 64'h0);
    chk("rst_if_pc", if_pc, 64'h0);
    rst = 1'b0;
    #1;
    chk1("post_rst_req_valid", imem_req_valid, 1'b1);
    chk("post_rst_req_addr", imem_req_addr, 64'h0);

    // Streaming start, then redirect on a cycle with a response and a pop.
    tbl[0]  = mk(0, 64'h0,   1, 1, 64'h0,   0, 64'h0);
    tbl[1]  = mk(0, 64'h0,   1, 1, 64'h4,   0, 64'h0);
    tbl[2]  = mk(0, 64'h0,   1, 0, 64'h0,   1, 64'h0);
    tbl[3]  = mk(0, 64'h0,   1, 1, 64'h8,   1, 64'h4);
    tbl[4]  = mk(0, 64'h0,   1, 1, 64'hC,   0, 64'h0);
    tbl[5]  = mk(0, 64'h0,   1, 0, 64'h0,   1, 64'h8);
    tbl[6]  = mk(0, 64'h0,   1, 1, 64'h10,  1, 64'hC);
    tbl[7]  = mk(0, 64'h0,   1, 1, 64'h14,  0, 64'h0);
    tbl[8]  = mk(1, 64'h200, 1, 0, 64'h0,   1, 64'h10);
    tbl[9]  = mk(0, 64'h0,   1, 1, 64'h200, 0, 64'h0);
    tbl[10] = mk(0, 64'h0,   1, 1, 64'h204, 0, 64'h0);
    tbl[11] = mk(0, 64'h0,   1, 0, 64'h0,   1, 64'h200);
    for (int i = 0; i < 12; i++) begin
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      if_ready       = tbl[i].rdy;
      cycle_begin();
      chk1($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].e_rv);
      if (tbl[i].e_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
      chk1($sformatf("v%0d_if_valid", i), if_valid, tbl[i].e_iv);
      if (tbl[i].e_iv) chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].e_pc);
      cycle_end();
    end
    redirect_valid = 1'b0;
    run(4);

    // Decode stall: credit cap, then issue resumes after the first pop.
    do_reset();
    base = nfire;
    run(10);
    chk("stall_accepts", 64'(nfire - base), 64'd2);
    chk1("stall_req_valid", imem_req_valid, 1'b0);
    if_ready = 1'b1;
    cycle_begin();
    chk1("pop_cycle_req_valid", imem_req_valid, 1'b0);
    chk1("pop_cycle_if_valid", if_valid, 1'b1);
    cycle_end();
    cycle_begin();
    chk1("resume_req_valid", imem_req_valid, 1'b1);
    chk("resume_req_addr", imem_req_addr, 64'h8);
    cycle_end();
    if_ready = 1'b0;
    run(4);

    // Reset with the buffer full.
    chk1("full_if_valid", if_valid, 1'b1);
    chk1("full_req_valid", imem_req_valid, 1'b0);
    do_reset();
    cycle_begin();
    chk1("midrst_if_valid", if_valid, 1'b0);
    chk1("midrst_req_valid", imem_req_valid, 1'b1);
    chk("midrst_req_addr", imem_req_addr, 64'h0);
    chk1("midrst_outstanding", dut.out_q == '0, 1'b1);
    cycle_end();
    run(4);

    // Misaligned redirect.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    cycle_begin();
    cycle_end();
    redirect_valid = 1'b0;
    redirect_pc    = '0;
`ifdef IFU_MISALIGN_CHECK_EN
    cycle_begin();
    chk1("misalign_fault", if_fetch_fault, 1'b1);
    chk1("misalign_req_valid", imem_req_valid, 1'b0);
    chk1("misalign_if_valid", if_valid, 1'b0);
    cycle_end();
    if_ready = 1'b1;
    base = nfire;
    run(6);
    chk("misalign_no_fires", 64'(nfire - base), 64'd0);
    chk1("misalign_if_valid_late", if_valid, 1'b0);
    do_reset();
    chk1("fault_cleared", if_fetch_fault, 1'b0);
`else
    cycle_begin();
    chk1("misalign_req_valid", imem_req_valid, 1'b1);
    chk("misalign_req_addr", imem_req_addr, 64'h100);
    chk1("misalign_if_valid", if_valid, 1'b0);
    cycle_end();
    if_ready = 1'b1;
    wait_first_pc("misalign_first_pc", 64'h100);
`endif

    // Redirect while two requests are in flight (latency 3).
    do_reset();
    lat      = 3;
    if_ready = 1'b1;
    run(2);
    redirect_valid = 1'b1;
    redirect_pc    = 64'h100;
    cycle_begin();
    chk1("flush_redir_req_valid", imem_req_valid, 1'b0);
    cycle_end();
    redirect_valid = 1'b0;
    chk1("flush_state", dut.state_q == S_FLUSH, 1'b1);
    cycle_begin();
    chk1("flush_drop1_req_valid", imem_req_valid, 1'b0);
    chk1("flush_drop1_if_valid", if_valid, 1'b0);
    cycle_end();
    cycle_begin();
    chk1("flush_drop2_req_valid", imem_req_valid, 1'b0);
    cycle_end();
    chk1("flush_back_to_fetch", dut.state_q == S_FETCH, 1'b1);
    cycle_begin();
    chk1("flush_req_valid", imem_req_valid, 1'b1);
    chk("flush_req_addr", imem_req_addr, 64'h100);
    cycle_end();
    wait_first_pc("flush_first_pc", 64'h100);
    lat = 1;

    // PC wrap at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle_begin();
    cycle_end();
    redirect_valid = 1'b0;
    wait_first_pc("wrap_first_pc", 64'hFFFF_FFFF_FFFF_FFFC);
    wait_first_pc("wrap_second_pc", 64'h0);

    // Random traffic against the scoreboard.
    rdy_rand = 1'b1;
    lat_rand = 1'b1;
    base     = npop;
    for (int k = 0; k < 400; k++) begin
      if_ready       = ($urandom_range(0, 2) != 0);
      redirect_valid = ($urandom_range(0, 24) == 0);
      redirect_pc    = {$urandom, $urandom} & ~64'h3;
      cycle_begin();
      cycle_end();
    end
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    run(20);
    chk1("rand_pops_min", (npop - base) >= 50, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
